// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the blank pattern and the hex glyph table (active-high, dp bit clear).
package seg7_pkg;

  // Bit positions inside the 8-bit segment word {a,b,c,d,e,f,g,dp}
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // All segments off, decimal point included
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Glyphs for 0..F; lower-case b and d keep them distinct from 8 and 0
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2,
    8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E,
    8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  // Glyph lookup for one nibble
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder; the decimal point is merged into
// the dp bit, which is always clear in the glyph table.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  // Table lookup with the decimal point ORed into the dp position
  always_comb begin
    seg_o         = hex_to_seg(nibble_i);
    seg_o[SEG_DP] = seg_o[SEG_DP] | dp_i;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver. One shared segment bus, one-hot
// digit enables, double-buffered display data that only changes on frame
// boundaries, leading-zero blanking, per-digit blink and PWM brightness.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lzb_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_done
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DIG_W  = $clog2(NUM_DIGITS);
  localparam int BLK_W  = $clog2(BLINK_FRAMES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  // XOR masks that turn active-high internal values into pin levels
  localparam logic [7:0]            SEG_PIN_OFF = {8{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_PIN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

  // Scan timing state
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    blink_on_q, blink_on_d;

  // Shadow (CPU side) and active (display side) buffers
  logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]   shadow_blink_q, shadow_blink_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] active_data_q, active_data_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [NUM_DIGITS-1:0]   active_blink_q, active_blink_d;

  // Pin-level output registers
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q;

  // Per-slot display decode
  logic                    slot_wrap;
  logic                    frame_end;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic                    cur_blink;
  logic                    blank_lz;
  logic                    zero_run;
  logic                    anode_on;
  logic [7:0]              dec_seg;

  assign slot_wrap = (slot_q == SLOT_LAST);
  assign frame_end = slot_wrap && (digit_q == DIG_LAST);

  // Slot, PWM, digit and blink-phase counters
  always_comb begin
    slot_d      = slot_q + SLOT_W'(1);
    pwm_d       = pwm_q + BRIGHT_W'(1);
    digit_d     = digit_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (slot_wrap) begin
      slot_d  = '0;
      pwm_d   = '0;
      digit_d = frame_end ? '0 : digit_q + DIG_W'(1);
    end
    if (frame_end) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // Double buffer: loads land in the shadow, the active copy only changes at
  // the frame boundary; a load on the boundary cycle bypasses the shadow
  always_comb begin
    shadow_data_d  = shadow_data_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blink_d = shadow_blink_q;
    pending_d      = pending_q;
    active_data_d  = active_data_q;
    active_dp_d    = active_dp_q;
    active_blink_d = active_blink_q;
    if (frame_end && load) begin
      shadow_data_d  = data_in;
      shadow_dp_d    = dp_in;
      shadow_blink_d = blink_mask;
      active_data_d  = data_in;
      active_dp_d    = dp_in;
      active_blink_d = blink_mask;
      pending_d      = 1'b0;
    end else if (frame_end && pending_q) begin
      active_data_d  = shadow_data_q;
      active_dp_d    = shadow_dp_q;
      active_blink_d = shadow_blink_q;
      pending_d      = 1'b0;
    end else if (load) begin
      shadow_data_d  = data_in;
      shadow_dp_d    = dp_in;
      shadow_blink_d = blink_mask;
      pending_d      = 1'b1;
    end
  end

  // Select the current digit's nibble, dp and blink bit from the active copy
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_q == DIG_W'(k)) begin
        cur_nibble = active_data_q[4*k +: 4];
        cur_dp     = active_dp_q[k];
        cur_blink  = active_blink_q[k];
      end
    end
  end

  // Leading-zero blanking: walk down from the top digit while nibbles are
  // zero; digit 0 is never considered so a value of 0 still shows one digit
  always_comb begin
    blank_lz = 1'b0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (active_data_q[4*k +: 4] == 4'h0);
      if ((digit_q == DIG_W'(k)) && zero_run) begin
        blank_lz = lzb_en;
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .nibble_i (cur_nibble),
    .dp_i     (cur_dp),
    .seg_o    (dec_seg)
  );

  // Final segment/anode values; slot cycle 0 is dead time against ghosting
  always_comb begin
    anode_on = (slot_q != '0) && (pwm_q <= brightness);
    an_d     = anode_on ? (NUM_DIGITS'(1) << digit_q) : '0;
    if (blank_lz || (!blink_on_q && cur_blink)) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = dec_seg;
    end
  end

  // State and pin registers; pin polarity is applied at the register input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q         <= '0;
      digit_q        <= '0;
      pwm_q          <= '0;
      blink_cnt_q    <= '0;
      blink_on_q     <= 1'b1;
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      shadow_blink_q <= '0;
      pending_q      <= 1'b0;
      active_data_q  <= '0;
      active_dp_q    <= '0;
      active_blink_q <= '0;
      seg_q          <= SEG_PIN_OFF;
      an_q           <= AN_PIN_OFF;
      frame_done_q   <= 1'b0;
    end else begin
      slot_q         <= slot_d;
      digit_q        <= digit_d;
      pwm_q          <= pwm_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_on_q     <= blink_on_d;
      shadow_data_q  <= shadow_data_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blink_q <= shadow_blink_d;
      pending_q      <= pending_d;
      active_data_q  <= active_data_d;
      active_dp_q    <= active_dp_d;
      active_blink_q <= active_blink_d;
      seg_q          <= seg_d ^ SEG_PIN_OFF;
      an_q           <= an_d ^ AN_PIN_OFF;
      frame_done_q   <= frame_end;
    end
  end

  assign seg_o      = seg_q;
  assign an_o       = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-level reference model
// derived from the display rules pushes the expected pin values each clock;
// a monitor pops and compares them against the DUT shortly after the edge.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int S  = 16;
  localparam int BW = 3;
  localparam int BF = 2;
  localparam bit AL = 1'b1;
  localparam int FL = N * S;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load = 1'b0;
  logic [4*N-1:0]  data_in = '0;
  logic [N-1:0]    dp_in = '0;
  logic [N-1:0]    blink_mask = '0;
  logic            lzb_en = 1'b0;
  logic [BW-1:0]   brightness = '1;
  logic [7:0]      seg_o;
  logic [N-1:0]    an_o;
  logic            frame_done;

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (S),
    .BRIGHT_W     (BW),
    .BLINK_FRAMES (BF),
    .ACTIVE_LOW   (AL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .lzb_en     (lzb_en),
    .brightness (brightness),
    .seg_o      (seg_o),
    .an_o       (an_o),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   seg;
    logic [N-1:0] an;
    logic         fd;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [7:0] GLYPH [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  // Reference model: cycle number since reset determines slot/digit/frame;
  // the display shows the last load issued before the current frame started
  initial begin : model
    int unsigned    cyc;
    int             slot, dig, frame;
    bit             lit, blank, fd;
    logic [3:0]     nib;
    logic [7:0]     seg;
    logic [N-1:0]   an;
    logic [4*N-1:0] act_data, new_data;
    logic [N-1:0]   act_dp, new_dp, act_blk, new_blk;
    exp_t           e;
    cyc = 0;
    act_data = '0; new_data = '0;
    act_dp = '0; new_dp = '0; act_blk = '0; new_blk = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        cyc = 0;
        act_data = '0; new_data = '0;
        act_dp = '0; new_dp = '0; act_blk = '0; new_blk = '0;
        e.seg = {8{AL}};
        e.an  = {N{AL}};
        e.fd  = 1'b0;
      end else begin
        slot  = int'(cyc % S);
        dig   = int'((cyc / S) % N);
        frame = int'(cyc / FL);
        lit   = (slot != 0) && ((slot % (1 << BW)) <= int'(brightness));
        blank = (lzb_en && dig != 0 && (act_data >> (4 * dig)) == '0) ||
                (((frame / BF) % 2 == 1) && act_blk[dig]);
        nib   = 4'(act_data >> (4 * dig));
        seg   = blank ? 8'h00 : (GLYPH[nib] | {7'b0, act_dp[dig]});
        an    = lit ? (N'(1) << dig) : '0;
        if (load) begin
          new_data = data_in;
          new_dp   = dp_in;
          new_blk  = blink_mask;
        end
        cyc = cyc + 1;
        fd  = (cyc % FL == 0);
        if (fd) begin
          act_data = new_data;
          act_dp   = new_dp;
          act_blk  = new_blk;
        end
        e.seg = AL ? ~seg : seg;
        e.an  = AL ? ~an : an;
        e.fd  = fd;
      end
      exp_q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  // Monitor: one expectation per clock, checked 1ns after the edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL queue at %0t: got no expectation, required one per cycle", $time);
      end else begin
        e = exp_q.pop_front();
        chk("seg_o", 16'(seg_o), 16'(e.seg));
        chk("an_o", 16'(an_o), 16'(e.an));
        chk("frame_done", 16'(frame_done), 16'(e.fd));
      end
    end
  end

  function automatic logic [4*N-1:0] rand_data();
    logic [4*N-1:0] d;
    int             top;
    top = $urandom_range(0, N);
    for (int k = 0; k < N; k++) begin
      d[4*k +: 4] = (k >= N - top) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    return d;
  endfunction

  // Inputs for cycle c (cycles counted from reset release)
  task automatic drive(input int c);
    int pos;
    pos  = c % FL;
    load = 1'b0;
    if (c == 0) begin
      load = 1'b1; data_in = 16'h3210; dp_in = '0; blink_mask = '0;
    end else if (c == 2 * FL + S + 3) begin
      load = 1'b1; data_in = 16'hFFFF; dp_in = 4'b0100; blink_mask = '0;
    end else if (c == 5 * FL + 7) begin
      load = 1'b1; data_in = 16'h0000; dp_in = '0; blink_mask = 4'b0001;
    end else if ((pos == FL - 1 && (c / FL) % 3 == 0) || $urandom_range(0, 24) == 0) begin
      load = 1'b1; data_in = rand_data(); dp_in = N'($urandom); blink_mask = N'($urandom);
    end
    if (pos == 0) begin
      lzb_en     = (c < 8 * FL) ? 1'b1 : 1'($urandom_range(0, 1));
      brightness = ($urandom_range(0, 1) == 1) ? '1 : BW'($urandom);
    end else if (c % S == 5 && $urandom_range(0, 3) == 0) begin
      brightness = BW'($urandom);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(i);
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin : stim
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    run_cycles(40 * FL + 21);
    // pending load mid-frame, then reset: the load must be lost
    load = 1'b1; data_in = 16'h8888; dp_in = '1; blink_mask = '0;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_cycles(12 * FL);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
